// File: rtl/choreo_pkg.sv
// Shared types for the choreo front-panel control slice.
// Pattern codes, pattern-select width and debouncer state encodings.
package choreo_pkg;

  localparam int PAT_W = 3;

  typedef enum logic [PAT_W-1:0] {
    PAT_KNIGHT  = 3'd0,
    PAT_WALK    = 3'd1,
    PAT_EXPAND  = 3'd2,
    PAT_BLINK   = 3'd3,
    PAT_ALT     = 3'd4,
    PAT_MARQUEE = 3'd5,
    PAT_SPARKLE = 3'd6,
    PAT_OFF     = 3'd7
  } pat_e;

  typedef enum logic [1:0] {
    DB_IDLE         = 2'd0,
    DB_PRESS_WAIT   = 2'd1,
    DB_PRESSED      = 2'd2,
    DB_RELEASE_WAIT = 2'd3
  } db_state_e;

  // Wraps naturally at the 3-bit boundary (7 -> 0 up, 0 -> 7 down).
  function automatic logic [PAT_W-1:0] pat_step(input logic [PAT_W-1:0] p, input logic up);
    return up ? PAT_W'(p + 1'b1) : PAT_W'(p - 1'b1);
  endfunction

endpackage

// File: rtl/choreo_input_ctrl_if.sv
// Front-panel bundle: raw buttons and enable in, generator control out.
// master = panel/driver side, slave = the control block.
interface choreo_input_ctrl_if;
  import choreo_pkg::*;

  logic             ena;
  logic             btn_next;
  logic             btn_prev;
  logic             btn_speed;
  logic             btn_pause;
  logic [PAT_W-1:0] pat_sel;
  logic             speed_sel;
  logic             pause;
  logic             cfg_changed;

  modport master (
    output ena, btn_next, btn_prev, btn_speed, btn_pause,
    input  pat_sel, speed_sel, pause, cfg_changed
  );

  modport slave (
    input  ena, btn_next, btn_prev, btn_speed, btn_pause,
    output pat_sel, speed_sel, pause, cfg_changed
  );

endinterface

// File: rtl/button_debouncer.sv
// Purpose: 2-flop synchroniser + debounce FSM turning one raw button into a single press pulse.
// Latency: press is high for one cycle after edge DEBOUNCE_CYCLES+3 (edge 1 samples the raw high).
// Backpressure: none; free-running, the pulse is never held or queued.
module button_debouncer
  import choreo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync;
  db_state_e        state;
  db_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             press_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync  <= 1'b0;
      state <= DB_IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync  <= sync1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      press <= press_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      DB_IDLE: begin
        if (sync) begin
          state_nxt = DB_PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      DB_PRESS_WAIT: begin
        if (!sync)               state_nxt = DB_IDLE;
        else if (cnt == CNT_MAX) state_nxt = DB_PRESSED;
        else                     cnt_nxt   = cnt + 1'b1;
      end
      DB_PRESSED: begin
        if (!sync) begin
          state_nxt = DB_RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      DB_RELEASE_WAIT: begin
        // A bounce back high re-enters PRESSED silently: no second pulse.
        if (sync)                state_nxt = DB_PRESSED;
        else if (cnt == CNT_MAX) state_nxt = DB_IDLE;
        else                     cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = DB_IDLE;
    endcase
  end

  always_comb begin
    press_nxt = (state == DB_PRESS_WAIT) && sync && (cnt == CNT_MAX);
  end

endmodule

// File: rtl/choreo_input_ctrl.sv
// Purpose: debounced buttons -> pat_sel/speed_sel/pause registers; CHOREO_AUTO_CYCLE_EN adds auto-advance.
// Latency: outputs and cfg_changed update one edge after the debounced press (edge DEBOUNCE_CYCLES+4).
// Backpressure: none; with ena low press pulses are dropped, not queued, and outputs hold.
module choreo_input_ctrl
  import choreo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES),
  parameter int AUTO_PERIOD     = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  choreo_input_ctrl_if.slave  io
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (AUTO_PERIOD < 2) begin : g_bad_auto
    $error("AUTO_PERIOD must be at least 2");
  end

  logic p_next, p_prev, p_speed, p_pause;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_next (
    .clk(clk), .rst_n(rst_n), .btn(io.btn_next), .press(p_next)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_prev (
    .clk(clk), .rst_n(rst_n), .btn(io.btn_prev), .press(p_prev)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_speed (
    .clk(clk), .rst_n(rst_n), .btn(io.btn_speed), .press(p_speed)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_pause (
    .clk(clk), .rst_n(rst_n), .btn(io.btn_pause), .press(p_pause)
  );

  logic [PAT_W-1:0] pat_q, pat_nxt;
  logic             speed_q, speed_nxt;
  logic             pause_q, pause_nxt;
  logic             cfg_changed_q;

`ifdef CHOREO_AUTO_CYCLE_EN
  localparam int                AUTO_W   = $clog2(AUTO_PERIOD);
  localparam logic [AUTO_W-1:0] AUTO_MAX = AUTO_W'(AUTO_PERIOD - 1);

  logic [AUTO_W-1:0] auto_cnt;
  logic              any_acc;
  logic              auto_step;

  assign any_acc   = io.ena && (p_next || p_prev || p_speed || p_pause);
  // A press in the wrap cycle wins: no auto-step, counter restarts.
  assign auto_step = io.ena && !pause_q && (auto_cnt == AUTO_MAX) && !any_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   auto_cnt <= '0;
    else if (any_acc)             auto_cnt <= '0;
    else if (io.ena && !pause_q)  auto_cnt <= (auto_cnt == AUTO_MAX) ? '0 : auto_cnt + 1'b1;
  end
`endif

  always_comb begin
    pat_nxt   = pat_q;
    speed_nxt = speed_q;
    pause_nxt = pause_q;
    if (io.ena) begin
      // Simultaneous next+prev cancel out.
      if (p_next && !p_prev)      pat_nxt = pat_step(pat_q, 1'b1);
      else if (p_prev && !p_next) pat_nxt = pat_step(pat_q, 1'b0);
      if (p_speed) speed_nxt = !speed_q;
      if (p_pause) pause_nxt = !pause_q;
    end
`ifdef CHOREO_AUTO_CYCLE_EN
    if (auto_step) pat_nxt = pat_step(pat_q, 1'b1);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q         <= PAT_KNIGHT;
      speed_q       <= 1'b0;
      pause_q       <= 1'b0;
      cfg_changed_q <= 1'b0;
    end else begin
      pat_q         <= pat_nxt;
      speed_q       <= speed_nxt;
      pause_q       <= pause_nxt;
      cfg_changed_q <= (pat_nxt != pat_q) || (speed_nxt != speed_q) || (pause_nxt != pause_q);
    end
  end

  assign io.pat_sel     = pat_q;
  assign io.speed_sel   = speed_q;
  assign io.pause       = pause_q;
  assign io.cfg_changed = cfg_changed_q;

endmodule

// File: tb/tb_choreo_input_ctrl.sv
// Directed bench for choreo_input_ctrl (default build, DEBOUNCE_CYCLES=16).
module tb_choreo_input_ctrl;
  import choreo_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  choreo_input_ctrl_if bus ();

  choreo_input_ctrl #(.DEBOUNCE_CYCLES(16), .AUTO_PERIOD(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_pat;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task set_btns(input logic [3:0] m);
    {bus.btn_next, bus.btn_prev, bus.btn_speed, bus.btn_pause} = m;
  endtask

  // Clean press: 24 cycles high, 24 cycles low; counts cfg_changed pulses.
  task do_press(input logic [3:0] m, output int pulses);
    pulses = 0;
    set_btns(m);
    repeat (24) begin
      tick;
      if (bus.cfg_changed) pulses++;
    end
    set_btns(4'b0000);
    repeat (24) begin
      tick;
      if (bus.cfg_changed) pulses++;
    end
  endtask

  task do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task test_reset;
    rst_n   = 1'b0;
    bus.ena = 1'b1;
    set_btns(4'b0000);
    tick;
    tick;
    total++; if (bus.pat_sel !== 3'd0)     begin bad++; $display("FAIL reset_pat got=%0d want=0", bus.pat_sel); end
    total++; if (bus.speed_sel !== 1'b0)   begin bad++; $display("FAIL reset_speed got=%b want=0", bus.speed_sel); end
    total++; if (bus.pause !== 1'b0)       begin bad++; $display("FAIL reset_pause got=%b want=0", bus.pause); end
    total++; if (bus.cfg_changed !== 1'b0) begin bad++; $display("FAIL reset_cfg got=%b want=0", bus.cfg_changed); end
    rst_n = 1'b1;
    tick;
    exp_pat = 3'd0;
  endtask

  task test_bounce;
    int pulses;
    pulses = 0;
    repeat (3) begin
      bus.btn_next = 1'b1;
      repeat (10) begin tick; if (bus.cfg_changed) pulses++; end
      bus.btn_next = 1'b0;
      repeat (10) begin tick; if (bus.cfg_changed) pulses++; end
    end
    repeat (10) begin tick; if (bus.cfg_changed) pulses++; end
    total++; if (pulses !== 0)          begin bad++; $display("FAIL bounce_cfg got=%0d want=0", pulses); end
    total++; if (bus.pat_sel !== 3'd0)  begin bad++; $display("FAIL bounce_pat got=%0d want=0", bus.pat_sel); end
  endtask

  task test_hold_latency;
    int pulses;
    pulses = 0;
    bus.btn_next = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick;
      if (bus.cfg_changed) pulses++;
      if (e == 19) begin
        total++; if (bus.pat_sel !== 3'd0) begin bad++; $display("FAIL hold_e19_pat got=%0d want=0", bus.pat_sel); end
        total++; if (bus.cfg_changed !== 1'b0) begin bad++; $display("FAIL hold_e19_cfg got=%b want=0", bus.cfg_changed); end
      end
      if (e == 20) begin
        total++; if (bus.pat_sel !== 3'd1) begin bad++; $display("FAIL hold_e20_pat got=%0d want=1", bus.pat_sel); end
        total++; if (bus.cfg_changed !== 1'b1) begin bad++; $display("FAIL hold_e20_cfg got=%b want=1", bus.cfg_changed); end
      end
      if (e == 21) begin
        total++; if (bus.cfg_changed !== 1'b0) begin bad++; $display("FAIL hold_e21_cfg got=%b want=0", bus.cfg_changed); end
      end
    end
    total++; if (pulses !== 1)         begin bad++; $display("FAIL hold_pulses got=%0d want=1", pulses); end
    total++; if (bus.pat_sel !== 3'd1) begin bad++; $display("FAIL hold_end_pat got=%0d want=1", bus.pat_sel); end
    bus.btn_next = 1'b0;
    repeat (24) tick;
    exp_pat = 3'd1;
  endtask

  task test_wrap;
    int pulses;
    logic [2:0] seq [7];
    seq = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    for (int i = 0; i < 7; i++) begin
      do_press(4'b1000, pulses);
      total++; if (bus.pat_sel !== seq[i]) begin bad++; $display("FAIL wrap_next%0d got=%0d want=%0d", i, bus.pat_sel, seq[i]); end
      total++; if (pulses !== 1) begin bad++; $display("FAIL wrap_next%0d_cfg got=%0d want=1", i, pulses); end
    end
    do_press(4'b0100, pulses);
    total++; if (bus.pat_sel !== 3'd7) begin bad++; $display("FAIL wrap_prev got=%0d want=7", bus.pat_sel); end
    total++; if (pulses !== 1)         begin bad++; $display("FAIL wrap_prev_cfg got=%0d want=1", pulses); end
    exp_pat = 3'd7;
  endtask

  task test_simultaneous;
    int pulses;
    do_press(4'b1100, pulses);
    total++; if (bus.pat_sel !== exp_pat) begin bad++; $display("FAIL nextprev_pat got=%0d want=%0d", bus.pat_sel, exp_pat); end
    total++; if (pulses !== 0)            begin bad++; $display("FAIL nextprev_cfg got=%0d want=0", pulses); end
    do_press(4'b0011, pulses);
    total++; if (bus.speed_sel !== 1'b1) begin bad++; $display("FAIL spdpause_speed got=%b want=1", bus.speed_sel); end
    total++; if (bus.pause !== 1'b1)     begin bad++; $display("FAIL spdpause_pause got=%b want=1", bus.pause); end
    total++; if (pulses !== 1)           begin bad++; $display("FAIL spdpause_cfg got=%0d want=1", pulses); end
  endtask

  task test_ena;
    int pulses;
    do_reset;
    bus.ena = 1'b0;
    do_press(4'b0010, pulses);
    total++; if (bus.speed_sel !== 1'b0) begin bad++; $display("FAIL ena0_speed got=%b want=0", bus.speed_sel); end
    total++; if (pulses !== 0)           begin bad++; $display("FAIL ena0_cfg got=%0d want=0", pulses); end
    bus.ena = 1'b1;
    do_press(4'b0010, pulses);
    total++; if (bus.speed_sel !== 1'b1) begin bad++; $display("FAIL ena1_speed got=%b want=1", bus.speed_sel); end
    total++; if (pulses !== 1)           begin bad++; $display("FAIL ena1_cfg got=%0d want=1", pulses); end
  endtask

  task test_reset_mid;
    bus.btn_pause = 1'b1;
    repeat (10) tick;
    rst_n = 1'b0;
    #1;
    total++; if (bus.speed_sel !== 1'b0) begin bad++; $display("FAIL midrst_speed got=%b want=0", bus.speed_sel); end
    total++; if (bus.pause !== 1'b0)     begin bad++; $display("FAIL midrst_pause got=%b want=0", bus.pause); end
    total++; if (bus.pat_sel !== 3'd0)   begin bad++; $display("FAIL midrst_pat got=%0d want=0", bus.pat_sel); end
    tick;
    tick;
    rst_n = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      tick;
      if (e == 19) begin
        total++; if (bus.pause !== 1'b0) begin bad++; $display("FAIL midrst_e19_pause got=%b want=0", bus.pause); end
      end
      if (e == 20) begin
        total++; if (bus.pause !== 1'b1) begin bad++; $display("FAIL midrst_e20_pause got=%b want=1", bus.pause); end
        total++; if (bus.cfg_changed !== 1'b1) begin bad++; $display("FAIL midrst_e20_cfg got=%b want=1", bus.cfg_changed); end
      end
    end
    bus.btn_pause = 1'b0;
    repeat (24) tick;
  endtask

  task test_no_auto;
    int pulses;
    do_press(4'b0001, pulses);
    total++; if (bus.pause !== 1'b0) begin bad++; $display("FAIL unpause got=%b want=0", bus.pause); end
    total++; if (pulses !== 1)       begin bad++; $display("FAIL unpause_cfg got=%0d want=1", pulses); end
    pulses = 0;
    repeat (200) begin tick; if (bus.cfg_changed) pulses++; end
    total++; if (pulses !== 0)         begin bad++; $display("FAIL idle_cfg got=%0d want=0", pulses); end
    total++; if (bus.pat_sel !== 3'd0) begin bad++; $display("FAIL idle_pat got=%0d want=0", bus.pat_sel); end
  endtask

  initial begin
    test_reset;
    test_bounce;
    test_hold_latency;
    test_wrap;
    test_simultaneous;
    test_ena;
    test_reset_mid;
    test_no_auto;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
